// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: ALU operations, operand/writeback
// selectors, the decoded bundle, buffer states and RV32I/RV64I opcodes.

package cpu_types_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_BEQ    = 5'd10,
        ALU_BNE    = 5'd11,
        ALU_BLT    = 5'd12,
        ALU_BGE    = 5'd13,
        ALU_BLTU   = 5'd14,
        ALU_BGEU   = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } alu_srcA_t;

    typedef enum logic {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } alu_srcB_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_src_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // pc and imm are sized for the widest datapath; bits above XLEN are zero.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        alu_op_t             alu_op;
        alu_srcA_t           src_a;
        alu_srcB_t           src_b;
        wb_src_t             wb_src;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [2:0]          mem_funct3;
        logic                branch;
        logic                jump;
        logic                csr;
        logic                fence;
        logic                illegal;
    } decode_bundle_t;

    // Integer ALU op for OP/OP-IMM; alt selects SUB/SRA on funct3 000/101.
    function automatic alu_op_t alu_base_op(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // M-extension op selected by funct3.
    function automatic alu_op_t alu_m_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

package instruction_type_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/decode_stage_logic.sv
// Purely combinational instruction decoder: raw instruction + pc in,
// fully populated decode bundle out.

module decode_logic
    import cpu_types_pkg::*;
    import instruction_type_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decode_bundle_t  dec
);

    localparam logic [63:0] IMM_MASK = (XLEN == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        shamt_ok;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign shamt_ok = (XLEN == 64)
                    ? (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000)
                    : (funct7 == 7'b0000000 || funct7 == 7'b0100000);

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Decode per opcode, then squash side effects for illegal ops and rd=x0.
    always_comb begin
        dec        = '0;
        dec.pc     = 64'(pc);
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.alu_op = ALU_ADD;
        dec.src_a  = SRCA_RS1;
        dec.src_b  = SRCB_RS2;
        dec.wb_src = WB_ALU;

        case (opcode)
            OP_LUI: begin
                dec.src_a     = SRCA_ZERO;
                dec.src_b     = SRCB_IMM;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec.src_a     = SRCA_PC;
                dec.src_b     = SRCB_IMM;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec.src_a     = SRCA_PC;
                dec.src_b     = SRCB_IMM;
                dec.imm       = imm_j;
                dec.wb_src    = WB_PC4;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec.src_b     = SRCB_IMM;
                dec.imm       = imm_i;
                dec.wb_src    = WB_PC4;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.illegal   = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_BEQ;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_BLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_BLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.src_b      = SRCB_IMM;
                dec.imm        = imm_i;
                dec.wb_src     = WB_MEM;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_funct3 = funct3;
                dec.illegal    = (funct3 == 3'b111) ||
                                 ((XLEN == 32) && (funct3 == 3'b011 || funct3 == 3'b110));
            end
            OP_STORE: begin
                dec.src_b      = SRCB_IMM;
                dec.imm        = imm_s;
                dec.mem_write  = 1'b1;
                dec.mem_funct3 = funct3;
                dec.illegal    = (XLEN == 32) ? (funct3 >= 3'b011) : (funct3 >= 3'b100);
            end
            OP_I_TYPE: begin
                dec.src_b     = SRCB_IMM;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_base_op(funct3, (funct3 == 3'b101) && instr[30]);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.illegal = !shamt_ok;
                end
            end
            OP_R_TYPE: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: dec.alu_op = alu_base_op(funct3, 1'b0);
                    7'b0100000: begin
                        if (funct3 == 3'b000 || funct3 == 3'b101) begin
                            dec.alu_op = alu_base_op(funct3, 1'b1);
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        if (ENABLE_M) begin
                            dec.alu_op = alu_m_op(funct3);
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_SYSTEM: begin
                dec.imm = imm_i;
                if (funct3 != 3'b000) begin
                    dec.csr       = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_src    = WB_CSR;
                end
            end
            OP_FENCE: begin
                dec.imm   = imm_i;
                dec.fence = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.csr       = 1'b0;
            dec.fence     = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
        dec.imm = dec.imm & IMM_MASK;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage top: combinational decoder feeding a registered two-entry
// skid buffer. in_ready depends only on the buffer state.

module decode_stage
    import cpu_types_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output decode_bundle_t  out_dec
);

    buf_state_t     state;
    decode_bundle_t head;
    decode_bundle_t skid;
    decode_bundle_t dec_now;
    logic           acc;
    logic           pop;

    decode_logic #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode_logic (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec_now)
    );

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_dec   = head;
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer FSM: head always holds the oldest entry, skid the younger one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        head  <= dec_now;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        head <= dec_now;
                    end else if (acc) begin
                        skid  <= dec_now;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.

module tb_decode_stage;
    import cpu_types_pkg::*;

    localparam int XLEN = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           flush;
    logic           in_valid;
    logic [31:0]    in_instr;
    logic [XLEN-1:0] in_pc;
    logic           out_ready;
    logic           in_ready;
    logic           out_valid;
    decode_bundle_t out_dec;
    logic           in_ready_m;
    logic           out_valid_m;
    decode_bundle_t out_dec_m;

    int checks = 0;
    int errors = 0;
    bit live   = 1'b0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;
    item_t q[$];
    bit    m_pop;
    bit    m_acc;
    decode_bundle_t exp0;
    decode_bundle_t exp1;

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec)
    );

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut_m (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .out_dec   (out_dec_m)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit rdy);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = $urandom & 32'hFFFF_FFFC;
        out_ready = rdy;
    endtask

    // Reference decode written from the ISA rules with plain integer arithmetic.
    function automatic decode_bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc, input bit enm);
        decode_bundle_t d;
        alu_op_t base_tab [8];
        alu_op_t m_tab [8];
        alu_op_t br_tab [8];
        int s, imm_i, imm_s, imm_b, imm_u, imm_j, imm;
        logic [2:0] f3;
        logic [6:0] f7;
        bit bad;
        base_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        m_tab    = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        br_tab   = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        s     = int'($signed(ins));
        imm_i = s >>> 20;
        imm_s = ((s >>> 25) <<< 5) | int'(ins[11:7]);
        imm_b = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
        imm_u = int'(ins & 32'hFFFF_F000);
        imm_j = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '0;
        d.pc  = {32'h0, pc};
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        imm = 0;
        bad = 1'b0;
        case (ins[6:0])
            7'h37: begin d.src_a = SRCA_ZERO; d.src_b = SRCB_IMM; imm = imm_u; d.reg_write = 1'b1; end
            7'h17: begin d.src_a = SRCA_PC; d.src_b = SRCB_IMM; imm = imm_u; d.reg_write = 1'b1; end
            7'h6F: begin d.src_a = SRCA_PC; d.src_b = SRCB_IMM; imm = imm_j; d.wb_src = WB_PC4;
                         d.jump = 1'b1; d.reg_write = 1'b1; end
            7'h67: begin d.src_b = SRCB_IMM; imm = imm_i; d.wb_src = WB_PC4; d.jump = 1'b1;
                         d.reg_write = 1'b1; bad = (f3 != 0); end
            7'h63: begin imm = imm_b; d.branch = 1'b1; bad = (f3 == 2 || f3 == 3);
                         if (!bad) d.alu_op = br_tab[f3]; end
            7'h03: begin d.src_b = SRCB_IMM; imm = imm_i; d.wb_src = WB_MEM; d.mem_read = 1'b1;
                         d.reg_write = 1'b1; d.mem_funct3 = f3; bad = (f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin d.src_b = SRCB_IMM; imm = imm_s; d.mem_write = 1'b1; d.mem_funct3 = f3;
                         bad = (f3 >= 3); end
            7'h13: begin d.src_b = SRCB_IMM; imm = imm_i; d.reg_write = 1'b1;
                         d.alu_op = (f3 == 5 && ins[30]) ? ALU_SRA : base_tab[f3];
                         if (f3 == 1 || f3 == 5) bad = !(f7 == 7'h00 || f7 == 7'h20); end
            7'h33: begin
                d.reg_write = 1'b1;
                if (f7 == 7'h00) d.alu_op = base_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) d.alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) d.alu_op = ALU_SRA;
                else if (f7 == 7'h01 && enm) d.alu_op = m_tab[f3];
                else bad = 1'b1;
            end
            7'h73: begin imm = imm_i; if (f3 != 0) begin d.csr = 1'b1; d.reg_write = 1'b1; d.wb_src = WB_CSR; end end
            7'h0F: begin imm = imm_i; d.fence = 1'b1; end
            default: bad = 1'b1;
        endcase
        d.imm = {32'h0, 32'(imm)};
        d.illegal = bad;
        if (bad) begin
            d.reg_write = 1'b0; d.mem_read = 1'b0; d.mem_write = 1'b0;
            d.branch = 1'b0; d.jump = 1'b0; d.csr = 1'b0; d.fence = 1'b0;
        end
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] r;
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = ops[k];
        else if (k == 11) r[6:0] = 7'h7F;
        if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
                0:       r[31:25] = 7'h00;
                1:       r[31:25] = 7'h20;
                default: r[31:25] = 7'h01;
            endcase
        end
        return r;
    endfunction

    // Model update: a bounded FIFO of accepted instructions, cleared by reset/flush.
    always @(posedge clk) begin
        if (!reset_n || flush) begin
            q.delete();
        end else begin
            m_pop = (q.size() > 0) && out_ready;
            m_acc = in_valid && (q.size() < 2);
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back('{in_instr, in_pc});
        end
    end

    // Every-cycle compare of handshake and head bundle against the model.
    always @(negedge clk) begin
        if (live) begin
            checkOutput("in_ready", 256'(in_ready), 256'(q.size() < 2));
            checkOutput("out_valid", 256'(out_valid), 256'(q.size() > 0));
            checkOutput("in_ready_m", 256'(in_ready_m), 256'(q.size() < 2));
            checkOutput("out_valid_m", 256'(out_valid_m), 256'(q.size() > 0));
            if (q.size() > 0) begin
                exp0 = model_decode(q[0].instr, q[0].pc, 1'b0);
                exp1 = model_decode(q[0].instr, q[0].pc, 1'b1);
                checkOutput("out_dec", 256'(out_dec), 256'(exp0));
                checkOutput("out_dec_m", 256'(out_dec_m), 256'(exp1));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset_n = 1'b0; flush = 1'b0;
        applyStimulus(1'b1, 32'h0050_0093, 1'b0);
        repeat (2) @(negedge clk);
        live = 1'b1;
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
        checkOutput("rst_dec_zero", 256'(out_dec), 256'(0));
        checkOutput("rst_alu_add", 256'(out_dec.alu_op), 256'(ALU_ADD));

        reset_n = 1'b1;
        applyStimulus(1'b1, 32'h0050_0093, 1'b1);
        @(negedge clk);
        checkOutput("addi_valid", 256'(out_valid), 256'(1));
        checkOutput("addi_rd", 256'(out_dec.rd), 256'(1));
        checkOutput("addi_imm", 256'(out_dec.imm), 256'(5));
        checkOutput("addi_alu", 256'(out_dec.alu_op), 256'(ALU_ADD));
        checkOutput("addi_srcb", 256'(out_dec.src_b), 256'(SRCB_IMM));
        checkOutput("addi_wr", 256'(out_dec.reg_write), 256'(1));

        applyStimulus(1'b1, 32'h4020_81B3, 1'b1);
        @(negedge clk);
        checkOutput("sub_alu", 256'(out_dec.alu_op), 256'(ALU_SUB));
        checkOutput("sub_rd", 256'(out_dec.rd), 256'(3));
        applyStimulus(1'b1, 32'hFE20_8EE3, 1'b1);
        @(negedge clk);
        checkOutput("beq_branch", 256'(out_dec.branch), 256'(1));
        checkOutput("beq_alu", 256'(out_dec.alu_op), 256'(ALU_BEQ));
        checkOutput("beq_imm", 256'(out_dec.imm), 256'(64'hFFFF_FFFC));

        applyStimulus(1'b1, 32'h0231_00B3, 1'b1);
        @(negedge clk);
        checkOutput("mul_nom_illegal", 256'(out_dec.illegal), 256'(1));
        checkOutput("mul_nom_wr", 256'(out_dec.reg_write), 256'(0));
        checkOutput("mul_m_alu", 256'(out_dec_m.alu_op), 256'(ALU_MUL));
        checkOutput("mul_m_wr", 256'(out_dec_m.reg_write), 256'(1));
        checkOutput("mul_m_illegal", 256'(out_dec_m.illegal), 256'(0));

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("drain_valid", 256'(out_valid), 256'(0));
        applyStimulus(1'b1, 32'h0081_2283, 1'b0);
        @(negedge clk);
        checkOutput("lw_mem_read", 256'(out_dec.mem_read), 256'(1));
        checkOutput("lw_funct3", 256'(out_dec.mem_funct3), 256'(3'b010));
        applyStimulus(1'b1, 32'h00A0_0313, 1'b0);
        @(negedge clk);
        checkOutput("two_in_ready", 256'(in_ready), 256'(0));
        applyStimulus(1'b1, 32'h0070_0393, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("held_in_ready", 256'(in_ready), 256'(0));
            checkOutput("held_head_rd", 256'(out_dec.rd), 256'(5));
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("second_rd", 256'(out_dec.rd), 256'(6));
        @(negedge clk);
        checkOutput("drained_valid", 256'(out_valid), 256'(0));

        applyStimulus(1'b1, 32'h0081_2283, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h00A0_0313, 1'b0);
        @(negedge clk);
        checkOutput("pre_flush_ready", 256'(in_ready), 256'(0));
        flush = 1'b1;
        applyStimulus(1'b1, 32'h0070_0393, 1'b0);
        @(negedge clk);
        checkOutput("flush_valid", 256'(out_valid), 256'(0));
        checkOutput("flush_ready", 256'(in_ready), 256'(1));
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);

        applyStimulus(1'b1, 32'h0000_0013, 1'b1);
        @(negedge clk);
        checkOutput("rd0_wr", 256'(out_dec.reg_write), 256'(0));
        checkOutput("rd0_illegal", 256'(out_dec.illegal), 256'(0));
        applyStimulus(1'b1, 32'h0000_00FF, 1'b1);
        @(negedge clk);
        checkOutput("op7f_illegal", 256'(out_dec.illegal), 256'(1));
        checkOutput("op7f_wr", 256'(out_dec.reg_write), 256'(0));

        applyStimulus(1'b1, 32'h0081_2283, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h00A0_0313, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 256'(out_valid), 256'(0));
        checkOutput("midrst_ready", 256'(in_ready), 256'(1));
        checkOutput("midrst_dec", 256'(out_dec), 256'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end

        flush = 1'b0;
        reset_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RV32I/RV64I decode stage with optional M extension. Sits between the IF/ID boundary and the register-read/issue logic. Accepts one instruction per cycle over a valid/ready handshake and fully decodes it: fields, sign-extended immediate, ALU op, operand sources, WB source, memory and control flags, illegal flag. Results are held in a registered 2-entry skid buffer, so backpressure never creates a combinational ready path from `out_ready` to `in_ready`.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `ENABLE_M`, 0, 1 decodes MUL/DIV/REM (funct7=0000001 on OP_R_TYPE); 0 makes them illegal.
- `clk` input 1 — the single clock; all state updates on its rising edge.
- `reset_n` input 1 — reset is synchronous and active-low.
- `flush` input 1 — discard all buffered and incoming instructions.
- `in_valid` input 1 — upstream instruction valid.
- `in_ready` output 1 — stage can accept.
- `in_instr` input 32 — raw instruction.
- `in_pc` input XLEN — instruction PC.
- `out_valid` output 1 — decoded bundle valid.
- `out_ready` input 1 — downstream accepts.
- `out_dec` output `decode_bundle_t` — pc, rs1, rs2, rd, imm[XLEN], alu_op, src_a, src_b, wb_src, reg_write, mem_read, mem_write, mem_funct3, branch, jump, csr, fence, illegal.

## Operation
- **Decode is combinational on `in_instr`** and written into the buffer on acceptance.
- **R/OP_I_TYPE**:
  - funct3 maps to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - I-type uses src_b=IMM. R-type uses src_b=RS2.
- **Shift immediates**:
  - XLEN=32 requires funct7 ∈ {0000000, 0100000}.
  - XLEN=64 checks only instr[31:26] ∈ {000000, 010000}.
- **LUI**: src_a=ZERO, src_b=IMM, ADD, wb=ALU.
- **AUIPC**: src_a=PC, src_b=IMM, ADD, wb=ALU.
- **JAL/JALR**: jump=1, wb=PC4. ALU computes the target (PC+imm or RS1+imm).
- **LOAD/STORE**: ADD RS1+IMM, mem_funct3=funct3.
- **BRANCH**: branch=1, alu_op from funct3 (BEQ..BGEU).
- **SYSTEM**:
  - funct3≠0 gives csr=1, reg_write=1.
  - funct3=0 (ECALL/EBREAK) gives all flags 0.
- **FENCE**: fence=1, no writes.
- **Immediates**: I/S/B/U/J formats, sign-extended to XLEN. U-imm is `{instr[31:12],12'b0}` sign-extended.
- **Illegal** is set for any of:
  - unknown opcode;
  - instr[1:0]≠11;
  - load funct3 ∈ {011 (XLEN=32), 110 (XLEN=32), 111};
  - store funct3 ≥ 011 (≥100 for XLEN=64);
  - branch funct3 ∈ {010, 011};
  - R-type funct7 ∉ {0000000, 0100000 (only with funct3 000/101), 0000001 (only if ENABLE_M)};
  - JALR funct3≠000.
- **When illegal=1**: reg_write, mem_read, mem_write, branch, jump, csr and fence are forced to 0.
- **rd=0**: reg_write forced to 0.
- **Buffer FSM** (`EMPTY`, `ONE`, `TWO`):
  - `in_ready` = (state≠TWO).
  - `out_valid` = (state≠EMPTY).
  - `out_dec` always shows the oldest entry.
- **Transitions** (`acc` = in_valid & in_ready, `pop` = out_valid & out_ready):
  - EMPTY: acc→ONE.
  - ONE: acc&!pop→TWO; !acc&pop→EMPTY; else stay.
  - TWO: pop→ONE (skid moves to head).
- **flush** has priority over everything: next state is EMPTY, and an instruction offered in the flush cycle is dropped.

## Timing
- Latency: `in_instr` accepted at edge N appears on `out_dec` with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 instr/cycle with `out_ready` held high.
- `in_ready` is a function of registered state only. No path from `out_ready` to `in_ready`.
- Reset (reset_n=0 sampled at an edge):
  - state=EMPTY, out_valid=0, out_dec=all zero (alu_op=ALU_ADD), in_ready=1 after that edge.
  - Reset asserted mid-transfer discards both entries.
- `out_dec` is stable while out_valid=1 & out_ready=0. Required by the handshake; the bench checks it.
- flush & reset_n=0 together behave as reset.

## Structure
- `cpu_types_pkg` holds:
  - `alu_op` extended with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - `alu_srcA_t` / `alu_srcB_t` with ZERO, PC, RS1 / RS2, IMM;
  - `wb_src_t` = {ALU, MEM, PC4, CSR};
  - `decode_bundle_t`, parametrised via a package-level XLEN_MAX=64 with truncation on output.
- `instruction_type_pkg` holds opcodes including OP_FENCE.
- Sub-module `decode_logic`: purely combinational instr→bundle. `decode_stage` owns the FSM and the two entry registers.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5) → 1 cycle later: out_valid=1, rd=1, imm=5, ALU_ADD, src_b=IMM, reg_write=1.
- 0x402081B3 (sub x3,x1,x2) then 0xFE208EE3 (beq x1,x2,-4), out_ready=1:
  - first bundle is ALU_SUB;
  - second is branch=1, ALU_BEQ, imm=0xFFFF_FFFC (XLEN=32).
- 0x023100B3 (mul x1,x2,x3):
  - ENABLE_M=0 → illegal=1, reg_write=0;
  - ENABLE_M=1 → ALU_MUL, reg_write=1.
- out_ready=0, push 0x00812283 (lw x5,8(x2)) and one more instruction:
  - state TWO, in_ready=0, third instruction held upstream;
  - release out_ready → in order lw (mem_read=1, mem_funct3=010) then second, with no loss or duplication.
- Buffer in TWO, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, no flushed entry ever appears.
- 0x00000093 with rd=0 variant and opcode 0x7F → reg_write=0; illegal=1 for opcode 0x7F.
